// File: rtl/pipeline_hazard_ctrl.sv
// Stall, flush and freeze sequencing for the five-stage LEGv8 pipeline.
// Also keeps saturating stall/flush counters for performance debug.
module pipeline_hazard_ctrl #(
  parameter int unsigned BRANCH_PENALTY = 1,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_read_reg_one,
  input  logic [4:0]       id_read_reg_two,
  input  logic             id_uses_reg_two,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_dest_reg,
  input  logic             branch_taken,
  input  logic             mem_wait,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StHold  = 2'd1,
    StFlush = 2'd2
  } state_e;

  localparam logic [3:0] PenReload   = 4'(BRANCH_PENALTY - 1);
  localparam bit         LongPenalty = (BRANCH_PENALTY > 1);

  state_e           state_q, state_d;
  logic [3:0]       pen_cnt_q, pen_cnt_d;
  logic             pending_flush_q, pending_flush_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  logic lu;
  logic do_branch;
  logic do_run;

  // XZR (r31) is never a real producer, so it cannot hazard.
  assign lu = ex_mem_read && (ex_dest_reg != 5'd31) &&
              ((ex_dest_reg == id_read_reg_one) ||
               (id_uses_reg_two && (ex_dest_reg == id_read_reg_two)));

  always_comb begin
    pc_write        = 1'b0;
    if_id_write     = 1'b0;
    id_ex_bubble    = 1'b0;
    if_id_flush     = 1'b0;
    id_ex_flush     = 1'b0;
    state_d         = state_q;
    pen_cnt_d       = pen_cnt_q;
    pending_flush_d = pending_flush_q;
    do_branch       = 1'b0;
    do_run          = 1'b0;

    if (reset) begin
      id_ex_bubble    = 1'b1;
      state_d         = StRun;
      pen_cnt_d       = 4'd0;
      pending_flush_d = 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (mem_wait) begin
            state_d         = StHold;
            pending_flush_d = branch_taken;
          end else if (branch_taken) begin
            do_branch = 1'b1;
          end else begin
            do_run = 1'b1;
          end
        end
        StHold: begin
          if (mem_wait) begin
            if (branch_taken) pending_flush_d = 1'b1;
          end else if (pending_flush_q || branch_taken) begin
            do_branch       = 1'b1;
            pending_flush_d = 1'b0;
          end else begin
            do_run  = 1'b1;
            state_d = StRun;
          end
        end
        StFlush: begin
          if (mem_wait) begin
            // Frozen: pen_cnt holds.
          end else if (branch_taken) begin
            do_branch = 1'b1;
          end else begin
            if_id_write = 1'b1;
            if_id_flush = 1'b1;
            if (pen_cnt_q != 4'd0) pen_cnt_d = pen_cnt_q - 4'd1;
            if (pen_cnt_q <= 4'd1) state_d = StRun;
          end
        end
        default: state_d = StRun;
      endcase
    end

    if (do_branch) begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      if (LongPenalty) begin
        state_d   = StFlush;
        pen_cnt_d = PenReload;
      end else begin
        state_d   = StRun;
      end
    end

    if (do_run) begin
      if (lu) begin
        id_ex_bubble = 1'b1;
      end else begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
      end
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (reset) begin
      stall_count_d = '0;
      flush_count_d = '0;
    end else begin
      if (!pc_write && (stall_count_q != '1)) stall_count_d = stall_count_q + CNT_W'(1);
      if (do_branch && (flush_count_q != '1)) flush_count_d = flush_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    state_q         <= state_d;
    pen_cnt_q       <= pen_cnt_d;
    pending_flush_q <= pending_flush_d;
    stall_count_q   <= stall_count_d;
    flush_count_q   <= flush_count_d;
  end

  assign state       = state_q;
  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (BRANCH_PENALTY=3, CNT_W=4).
// Each driven cycle queues its expected controls/state/counters; a negedge monitor compares.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_read_reg_one, id_read_reg_two, ex_dest_reg;
  logic       id_uses_reg_two, ex_mem_read, branch_taken, mem_wait;
  logic       pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush;
  logic [1:0] state;
  logic [3:0] stall_count, flush_count;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .BRANCH_PENALTY(3),
    .CNT_W         (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .id_read_reg_one(id_read_reg_one),
    .id_read_reg_two(id_read_reg_two),
    .id_uses_reg_two(id_uses_reg_two),
    .ex_mem_read    (ex_mem_read),
    .ex_dest_reg    (ex_dest_reg),
    .branch_taken   (branch_taken),
    .mem_wait       (mem_wait),
    .pc_write       (pc_write),
    .if_id_write    (if_id_write),
    .id_ex_bubble   (id_ex_bubble),
    .if_id_flush    (if_id_flush),
    .id_ex_flush    (id_ex_flush),
    .state          (state),
    .stall_count    (stall_count),
    .flush_count    (flush_count)
  );

  // Control bundle: {pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush}
  localparam logic [4:0] CRun   = 5'b11000;
  localparam logic [4:0] CStall = 5'b00100;
  localparam logic [4:0] CRst   = 5'b00100;
  localparam logic [4:0] CFrz   = 5'b00000;
  localparam logic [4:0] CBr    = 5'b11011;
  localparam logic [4:0] CFl    = 5'b01010;

  typedef struct packed {
    logic [4:0] ctl;
    logic [1:0] st;
    logic [3:0] sc;
    logic [3:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   exp_sc = 0;
  int   exp_fc = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check_val("ctl", 32'({pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush}),
                32'(e.ctl));
      check_val("state", 32'(state), 32'(e.st));
      check_val("stall_count", 32'(stall_count), 32'(e.sc));
      check_val("flush_count", 32'(flush_count), 32'(e.fc));
    end
  end

  // One clock cycle of stimulus plus its expected outcome.
  task automatic cyc(input logic rst, input logic mr, input logic [4:0] dr, input logic [4:0] r1,
                     input logic [4:0] r2, input logic u2, input logic bt, input logic mw,
                     input logic [4:0] ctl, input logic [1:0] st);
    exp_t e;
    @(posedge clk);
    #1;
    reset           = rst;
    ex_mem_read     = mr;
    ex_dest_reg     = dr;
    id_read_reg_one = r1;
    id_read_reg_two = r2;
    id_uses_reg_two = u2;
    branch_taken    = bt;
    mem_wait        = mw;
    e.ctl = ctl;
    e.st  = st;
    e.sc  = 4'(exp_sc);
    e.fc  = 4'(exp_fc);
    exp_q.push_back(e);
    if (rst) begin
      exp_sc = 0;
      exp_fc = 0;
    end else begin
      if (!ctl[4] && exp_sc < 15) exp_sc++;
      if (ctl[0] && exp_fc < 15) exp_fc++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, CRun, 2'd0);
  endtask

  task automatic wait_cyc(input logic bt, input logic [4:0] ctl, input logic [1:0] st);
    cyc(0, 0, 0, 0, 0, 0, bt, 1, ctl, st);
  endtask

  initial begin
    reset = 1'b1;
    {ex_mem_read, id_uses_reg_two, branch_taken, mem_wait} = '0;
    {ex_dest_reg, id_read_reg_one, id_read_reg_two} = '0;
    @(posedge clk);

    cyc(1, 0, 0, 0, 0, 0, 0, 0, CRst, 2'd0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, CRst, 2'd0);
    idle(3);

    // Load-use on Rn, then the XZR exemption.
    cyc(0, 1, 5'd2, 5'd2, 5'd0, 0, 0, 0, CStall, 2'd0);
    idle(1);
    cyc(0, 1, 5'd31, 5'd31, 5'd0, 0, 0, 0, CRun, 2'd0);
    // Match on Rm only matters when it is actually read.
    cyc(0, 1, 5'd5, 5'd0, 5'd5, 0, 0, 0, CRun, 2'd0);
    cyc(0, 1, 5'd5, 5'd0, 5'd5, 1, 0, 0, CStall, 2'd0);
    idle(1);

    // Branch with concurrent load-use: load-use ignored throughout.
    cyc(0, 1, 5'd2, 5'd2, 5'd0, 0, 1, 0, CBr, 2'd0);
    cyc(0, 1, 5'd2, 5'd2, 5'd0, 0, 0, 0, CFl, 2'd2);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, CFl, 2'd2);
    idle(1);

    // mem_wait 4 cycles with branch in the 2nd: flush happens when it drops.
    wait_cyc(0, CFrz, 2'd0);
    wait_cyc(1, CFrz, 2'd1);
    wait_cyc(0, CFrz, 2'd1);
    wait_cyc(0, CFrz, 2'd1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, CBr, 2'd1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, CFl, 2'd2);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, CFl, 2'd2);
    idle(1);

    // mem_wait inside FLUSH holds the penalty counter.
    cyc(0, 0, 0, 0, 0, 0, 1, 0, CBr, 2'd0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, CFl, 2'd2);
    wait_cyc(0, CFrz, 2'd2);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, CFl, 2'd2);
    idle(1);

    // Branch during FLUSH restarts the penalty; stall counter saturates here.
    cyc(0, 0, 0, 0, 0, 0, 1, 0, CBr, 2'd0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, CFl, 2'd2);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, CBr, 2'd2);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, CFl, 2'd2);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, CFl, 2'd2);
    idle(1);

    // HOLD exit without pending branch applies load-use.
    wait_cyc(0, CFrz, 2'd0);
    cyc(0, 1, 5'd7, 5'd7, 5'd0, 0, 0, 0, CStall, 2'd1);
    idle(1);

    // Branch coincident with mem_wait entry from RUN.
    wait_cyc(1, CFrz, 2'd0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, CBr, 2'd1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, CFl, 2'd2);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, CFl, 2'd2);
    idle(1);

    // Long memory wait.
    wait_cyc(0, CFrz, 2'd0);
    for (int i = 0; i < 19; i++) wait_cyc(0, CFrz, 2'd1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, CRun, 2'd1);
    idle(1);

    // Drive flush_count into saturation.
    for (int i = 0; i < 11; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 1, 0, CBr, 2'd0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, CFl, 2'd2);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, CFl, 2'd2);
    end
    idle(1);

    // Reset in the middle of FLUSH.
    cyc(0, 0, 0, 0, 0, 0, 1, 0, CBr, 2'd0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, CFl, 2'd2);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, CRst, 2'd2);
    idle(2);

    @(posedge clk);
    @(negedge clk);
    #1;
    check_val("drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
